// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and the parity helper
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Widest supported data word; narrower words are zero-extended before parity.
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int                       ptype);
        logic x;
        x = ^data;
        return (ptype == PARITY_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: 2-flop synchroniser, plus a 3-tap
// majority filter when UART_RX_MAJORITY_VOTE_EN is defined (adds one clock).
module uart_rx_sampler (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_serial_rx,
    output logic rx_s
);

    logic sync_p0;
    logic sync_p1;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= i_serial_rx;
            sync_p1 <= sync_p0;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic tap_p2;
    logic tap_p3;

    // Vote window is centred on tap_p2, so every decision lands one clock later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tap_p2 <= 1'b1;
            tap_p3 <= 1'b1;
        end else begin
            tap_p2 <= sync_p1;
            tap_p3 <= tap_p2;
        end
    end

    assign rx_s = (sync_p1 & tap_p2) | (sync_p1 & tap_p3) | (tap_p2 & tap_p3);
`else
    assign rx_s = sync_p1;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled mid-bit capture of start/data/parity/stop bits with
// parity and framing error flags. Optional UART_RX_MAJORITY_VOTE_EN sample voting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int P_DATA_BITS    = 8,
    parameter int P_PARITY_TYPE  = 0,
    parameter int P_STOP_BITS    = 1,
    parameter int P_CLKS_PER_BIT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_serial_rx,
    output logic [P_DATA_BITS-1:0] o_rx_data,
    output logic                   o_rx_data_valid,
    output logic                   o_parity_err,
    output logic                   o_frame_err,
    output logic                   o_rx_busy
);

    localparam int CNT_W = $clog2(P_CLKS_PER_BIT);
    localparam int BIT_W = $clog2(P_DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(P_CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(P_CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(P_DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_DONE = BIT_W'(P_STOP_BITS);
    localparam bit               HAS_PARITY = (P_PARITY_TYPE != PARITY_NONE);

    logic                     rx_s;
    rx_state_t                state;
    logic [CNT_W-1:0]         clk_cnt;
    logic [BIT_W-1:0]         bit_cnt;
    logic [P_DATA_BITS-1:0]   shreg;
    logic [MAX_DATA_BITS-1:0] shreg_ext;
    logic                     par_err;
    logic                     frm_err;
    logic                     armed;
    logic                     bit_tick;

    uart_rx_sampler u_sampler (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_serial_rx (i_serial_rx),
        .rx_s        (rx_s)
    );

    assign shreg_ext = MAX_DATA_BITS'(shreg);
    assign bit_tick  = (clk_cnt == FULL_M1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            clk_cnt         <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            par_err         <= 1'b0;
            frm_err         <= 1'b0;
            armed           <= 1'b1;
            o_rx_data       <= '0;
            o_rx_data_valid <= 1'b0;
            o_parity_err    <= 1'b0;
            o_frame_err     <= 1'b0;
            o_rx_busy       <= 1'b0;
        end else begin
            o_rx_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    // After a framing error (e.g. a break) the line must go high
                    // before another falling edge can count as a start bit.
                    if (!armed) begin
                        if (rx_s) armed <= 1'b1;
                    end else if (!rx_s) begin
                        state     <= START;
                        o_rx_busy <= 1'b1;
                    end
                end

                START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            state     <= IDLE;
                            o_rx_busy <= 1'b0;
                        end else begin
                            state   <= DATA;
                            par_err <= 1'b0;
                            frm_err <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[P_DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (HAS_PARITY) state <= PARITY;
                            else            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        par_err <= rx_s ^ calc_parity(shreg_ext, P_PARITY_TYPE);
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    // Present the frame one clock after the last stop sample rather
                    // than waiting out the stop bit, so back-to-back frames are caught.
                    if (bit_cnt == STOP_DONE) begin
                        state           <= IDLE;
                        clk_cnt         <= '0;
                        bit_cnt         <= '0;
                        o_rx_busy       <= 1'b0;
                        o_rx_data       <= shreg;
                        o_parity_err    <= par_err;
                        o_frame_err     <= frm_err;
                        o_rx_data_valid <= 1'b1;
                        armed           <= ~frm_err;
                    end else if (bit_tick) begin
                        clk_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (!rx_s) frm_err <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    clk_cnt   <= '0;
                    bit_cnt   <= '0;
                    o_rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one 8N1 receiver and one 8E1 receiver.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE_LAT = 1;
`else
    localparam int VOTE_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] data0, data1;
    logic       vld0, vld1, perr0, perr1, ferr0, ferr1, busy0, busy1;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.P_DATA_BITS(8), .P_PARITY_TYPE(0), .P_STOP_BITS(1), .P_CLKS_PER_BIT(CPB)) dut0 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_serial_rx     (rx0),
        .o_rx_data       (data0),
        .o_rx_data_valid (vld0),
        .o_parity_err    (perr0),
        .o_frame_err     (ferr0),
        .o_rx_busy       (busy0)
    );

    uart_rx #(.P_DATA_BITS(8), .P_PARITY_TYPE(1), .P_STOP_BITS(1), .P_CLKS_PER_BIT(CPB)) dut1 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_serial_rx     (rx1),
        .o_rx_data       (data1),
        .o_rx_data_valid (vld1),
        .o_parity_err    (perr1),
        .o_frame_err     (ferr1),
        .o_rx_busy       (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (vld0) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_valid", 32'd1, 32'd0);
            end else begin
                m0 = q0.pop_front();
                check("dut0_data", 32'(data0), 32'(m0.data));
                check("dut0_parity_err", 32'(perr0), 32'(m0.perr));
                check("dut0_frame_err", 32'(ferr0), 32'(m0.ferr));
                check("dut0_valid_cycle", 32'(cyc), 32'(m0.at));
            end
        end
    end

    always @(negedge clk) begin
        if (vld1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                m1 = q1.pop_front();
                check("dut1_data", 32'(data1), 32'(m1.data));
                check("dut1_parity_err", 32'(perr1), 32'(m1.perr));
                check("dut1_frame_err", 32'(ferr1), 32'(m1.ferr));
                check("dut1_valid_cycle", 32'(cyc), 32'(m1.at));
            end
        end
    end

    // All stimulus tasks start and end 1 ns after a rising edge.
    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input int with_par,
                              input logic par, input logic stop, input logic exp_perr);
        exp_t e;
        e.data = d;
        e.perr = exp_perr;
        e.ferr = ~stop;
        // 2 sync clocks + IDLE detect, half bit to start centre, one bit per sample, +1 present.
        e.at   = cyc + 3 + CPB / 2 + CPB * (9 + with_par) + 1 + VOTE_LAT;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (with_par != 0) drive_bit(which, par);
        drive_bit(which, stop);
        if (which == 0) rx0 = 1'b1;
        else            rx1 = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(data0), 32'd0);
        check({tag, "_valid"}, 32'(vld0), 32'd0);
        check({tag, "_perr"}, 32'(perr0), 32'd0);
        check({tag, "_ferr"}, 32'(ferr0), 32'd0);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        idle(20);

        // Clean 8N1 frame
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1'b0);
        idle(2 * CPB);
        wait_drain();

        // False start: 5-clock low pulse
        start = cyc;
        rx0 = 1'b0;
        idle(5);
        rx0 = 1'b1;
        repeat (6 + VOTE_LAT) @(negedge clk);
        check("false_start_busy_high", 32'(busy0), 32'd1);
        check("false_start_cycle", 32'(cyc), 32'(start + 10 + VOTE_LAT));
        @(negedge clk);
        check("false_start_busy_low", 32'(busy0), 32'd0);
        @(posedge clk);
        #1;
        idle(3 * CPB);

        // Even parity on dut1: wrong then right parity bit
        send_frame(1, 8'h3C, 1, 1'b1, 1'b1, 1'b1);
        idle(CPB);
        send_frame(1, 8'h3C, 1, 1'b0, 1'b1, 1'b0);
        idle(CPB);
        send_frame(1, 8'h07, 1, 1'b1, 1'b1, 1'b0);
        idle(CPB);

        // Framing error, then a break lasting three frame times
        send_frame(0, 8'h55, 0, 1'b0, 1'b0, 1'b0);
        idle(2 * CPB);
        begin
            exp_t e;
            e.data = 8'h00;
            e.perr = 1'b0;
            e.ferr = 1'b1;
            e.at   = cyc + 3 + CPB / 2 + CPB * 9 + 1 + VOTE_LAT;
            q0.push_back(e);
        end
        rx0 = 1'b0;
        idle(3 * 10 * CPB);
        rx0 = 1'b1;
        idle(4 * CPB);
        check("break_ferr_hold", 32'(ferr0), 32'd1);
        check("break_busy_idle", 32'(busy0), 32'd0);
        wait_drain();

        // Back-to-back frames, no idle gap
        send_frame(0, 8'h01, 0, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'hFF, 0, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'h80, 0, 1'b0, 1'b1, 1'b0);
        idle(2 * CPB);
        wait_drain();

        // Asynchronous reset while idle: outputs clear with no clock edge
        rst = 1'b1;
        #1;
        check_reset_outputs("idle_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(CPB);

        // Reset in the middle of data bits abandons the frame
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        check("midframe_busy_before", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        check("midframe_rst_busy", 32'(busy0), 32'd0);
        check("midframe_rst_valid", 32'(vld0), 32'd0);
        rx0 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3 * CPB);
        send_frame(0, 8'h7E, 0, 1'b0, 1'b1, 1'b0);
        idle(2 * CPB);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
